// File: rtl/align_pkg.sv
// align_pkg: shared widths and helpers for the alignment stage.
// Used by align_lane and align_stage_pipe.
package align_pkg;

  localparam int LANES_D = 9;
  localparam int PP_W_D  = 5;
  localparam int EXP_W_D = 5;
  localparam int OUT_W_D = 16;

  // Most negative value of a w-bit signed exponent.
  function automatic int exp_neg_inf(input int w);
    return -(1 << (w - 1));
  endfunction

  // LSB position of lane i in a packed vector of w-bit lanes.
  function automatic int lane_lsb(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/align_lane.sv
// align_lane: combinational shifter for one lane.
// Sticky output exists only with ALIGN_STICKY_EN.
module align_lane
  import align_pkg::*;
#(
  parameter int PP_W      = PP_W_D,
  parameter int EXP_W     = EXP_W_D,
  parameter int OUT_W     = OUT_W_D,
  parameter int ALIGN_LSB = OUT_W - PP_W
) (
  input  logic [PP_W-1:0]  pp_i,
  input  logic [EXP_W:0]   shift_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] aligned_o
`ifdef ALIGN_STICKY_EN
  , output logic           sticky_o
`endif
);

  logic [OUT_W-1:0]        pre;
  logic signed [OUT_W-1:0] pre_s;
  logic signed [OUT_W-1:0] shr_s;
  logic [31:0]             sh;

  assign sh    = 32'(shift_i);
  assign pre   = {{(OUT_W-PP_W){pp_i[PP_W-1]}}, pp_i} << ALIGN_LSB;
  assign pre_s = pre;
  assign shr_s = pre_s >>> sh;

  // Saturate to sign fill once every bit has been shifted out.
  always_comb begin
    aligned_o = '0;
    if (en_i) begin
      if (sh >= 32'(OUT_W)) aligned_o = {OUT_W{pre[OUT_W-1]}};
      else                  aligned_o = shr_s;
    end
  end

`ifdef ALIGN_STICKY_EN
  logic [OUT_W-1:0] mask;

  // Mask of bits dropped below the LSB; all ones on overshift.
  always_comb begin
    mask     = ~({OUT_W{1'b1}} << sh);
    sticky_o = en_i & (|(pre & mask));
  end
`endif

endmodule

// File: rtl/align_stage_pipe.sv
// align_stage_pipe: 2-stage exponent-align pipeline with valid/ready.
// Optional sticky outputs enabled by macro ALIGN_STICKY_EN.
module align_stage_pipe
  import align_pkg::*;
#(
  parameter int LANES     = LANES_D,
  parameter int PP_W      = PP_W_D,
  parameter int EXP_W     = EXP_W_D,
  parameter int OUT_W     = OUT_W_D,
  parameter int ALIGN_LSB = OUT_W - PP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PP_W-1:0]  in_pp,
  input  logic [LANES*EXP_W-1:0] in_exp,
  input  logic [LANES-1:0]       in_lane_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_pp,
  output logic [EXP_W-1:0]       out_exp_max
`ifdef ALIGN_STICKY_EN
  , output logic [LANES-1:0]     out_sticky
`endif
);

  localparam logic [EXP_W-1:0] NEG_INF = EXP_W'(exp_neg_inf(EXP_W));

  logic                   s1_valid_q, s1_valid_d;
  logic                   s2_valid_q, s2_valid_d;
  logic                   s1_adv, s2_adv;
  logic                   s1_load, s2_load;
  logic [LANES*PP_W-1:0]  s1_pp_q;
  logic [LANES*EXP_W-1:0] s1_exp_q;
  logic [LANES-1:0]       s1_en_q;
  logic [EXP_W-1:0]       s1_max_q, s1_max_d;
  logic [LANES*OUT_W-1:0] s2_pp_q, s2_pp_d;
  logic [EXP_W-1:0]       s2_max_q;

  assign s2_adv     = !s2_valid_q || out_ready;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready   = s1_adv;
  assign s1_load    = s1_adv && in_valid;
  assign s2_load    = s2_adv && s1_valid_q;
  assign s1_valid_d = s1_adv ? in_valid : s1_valid_q;
  assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

  assign out_valid   = s2_valid_q;
  assign out_pp      = s2_pp_q;
  assign out_exp_max = s2_max_q;

  // Signed max of enabled exponents; none enabled gives NEG_INF.
  always_comb begin
    s1_max_d = NEG_INF;
    for (int i = 0; i < LANES; i++) begin
      if (in_lane_en[i] &&
          $signed(in_exp[lane_lsb(i, EXP_W) +: EXP_W]) > $signed(s1_max_d))
        s1_max_d = in_exp[lane_lsb(i, EXP_W) +: EXP_W];
    end
  end

`ifdef ALIGN_STICKY_EN
  logic [LANES-1:0] s2_st_q, s2_st_d;
  assign out_sticky = s2_st_q;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [EXP_W-1:0] e;
    logic [EXP_W:0]   sh;
    assign e  = s1_exp_q[g*EXP_W +: EXP_W];
    assign sh = {s1_max_q[EXP_W-1], s1_max_q} - {e[EXP_W-1], e};
    align_lane #(
      .PP_W     (PP_W),
      .EXP_W    (EXP_W),
      .OUT_W    (OUT_W),
      .ALIGN_LSB(ALIGN_LSB)
    ) u_lane (
      .pp_i     (s1_pp_q[g*PP_W +: PP_W]),
      .shift_i  (sh),
      .en_i     (s1_en_q[g]),
      .aligned_o(s2_pp_d[g*OUT_W +: OUT_W])
`ifdef ALIGN_STICKY_EN
      , .sticky_o(s2_st_d[g])
`endif
    );
  end

  // S1: capture the beat and its max exponent on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pp_q    <= '0;
      s1_exp_q   <= '0;
      s1_en_q    <= '0;
      s1_max_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_pp_q  <= in_pp;
        s1_exp_q <= in_exp;
        s1_en_q  <= in_lane_en;
        s1_max_q <= s1_max_d;
      end
    end
  end

  // S2: register aligned lanes; hold while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_pp_q    <= '0;
      s2_max_q   <= '0;
`ifdef ALIGN_STICKY_EN
      s2_st_q    <= '0;
`endif
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_pp_q  <= s2_pp_d;
        s2_max_q <= s1_max_q;
`ifdef ALIGN_STICKY_EN
        s2_st_q  <= s2_st_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_align_stage_pipe.sv
// tb_align_stage_pipe: scoreboard bench for align_stage_pipe.
// Sticky outputs are checked when ALIGN_STICKY_EN is defined.
module tb_align_stage_pipe;

  localparam int L  = 9;
  localparam int PW = 5;
  localparam int EW = 5;
  localparam int OW = 16;
  localparam int AL = OW - PW;

  typedef struct packed {
    logic [L*OW-1:0] pp;
    logic [EW-1:0]   mx;
    logic [L-1:0]    st;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [L*PW-1:0] in_pp;
  logic [L*EW-1:0] in_exp;
  logic [L-1:0]    in_lane_en;
  logic            out_valid;
  logic            out_ready;
  logic [L*OW-1:0] out_pp;
  logic [EW-1:0]   out_exp_max;
`ifdef ALIGN_STICKY_EN
  logic [L-1:0]    out_sticky;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;

  always #5 clk = ~clk;

  align_stage_pipe #(
    .LANES(L), .PP_W(PW), .EXP_W(EW), .OUT_W(OW), .ALIGN_LSB(AL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pp      (in_pp),
    .in_exp     (in_exp),
    .in_lane_en (in_lane_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pp     (out_pp),
    .out_exp_max(out_exp_max)
`ifdef ALIGN_STICKY_EN
    , .out_sticky(out_sticky)
`endif
  );

  task automatic check(input string tag, input logic [159:0] got,
                       input logic [159:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [L*PW-1:0] pp,
                                 input logic [L*EW-1:0] ex,
                                 input logic [L-1:0] en);
    exp_t r;
    int mx, e, p, pre, v, sh;
    mx = -(1 << (EW - 1));
    for (int i = 0; i < L; i++) begin
      e = $signed(ex[i*EW +: EW]);
      if (en[i] && e > mx) mx = e;
    end
    r    = '0;
    r.mx = mx[EW-1:0];
    for (int i = 0; i < L; i++) begin
      if (en[i]) begin
        p   = $signed(pp[i*PW +: PW]);
        e   = $signed(ex[i*EW +: EW]);
        sh  = mx - e;
        pre = p * (1 << AL);
        if (sh >= OW) begin
          v       = (pre < 0) ? -1 : 0;
          r.st[i] = (pre != 0);
        end else begin
          v       = pre >>> sh;
          r.st[i] = ((pre & ((1 << sh) - 1)) != 0);
        end
        r.pp[i*OW +: OW] = v[OW-1:0];
      end
    end
    return r;
  endfunction

  // Scoreboard: compare head while valid, pop on transfer, push inputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        check("sb_has_entry", 160'(sb.size() > 0), 160'(1));
        if (sb.size() > 0) begin
          check("sb_pp", out_pp, sb[0].pp);
          check("sb_exp_max", out_exp_max, sb[0].mx);
`ifdef ALIGN_STICKY_EN
          check("sb_sticky", out_sticky, sb[0].st);
`endif
          if (out_ready) begin
            void'(sb.pop_front());
            popped++;
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(in_pp, in_exp, in_lane_en));
    end
  end

  task automatic send(input logic [L*PW-1:0] p, input logic [L*EW-1:0] e,
                      input logic [L-1:0] en);
    bit ok;
    ok         = 1'b0;
    in_pp      = p;
    in_exp     = e;
    in_lane_en = en;
    in_valid   = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 160'(in_ready), 160'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [L*PW-1:0] p;
    logic [L*EW-1:0] e;
    logic [L-1:0]    en;
    p  = (L*PW)'({$urandom(), $urandom()});
    e  = (L*EW)'({$urandom(), $urandom()});
    en = L'($urandom());
    send(p, e, en);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 160'(sb.size()), 160'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [L*PW-1:0] p;
    logic [L*EW-1:0] e;
    int              base;
    bit              saw_low;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_pp      = '0;
    in_exp     = '0;
    in_lane_en = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 160'(out_valid), 160'(0));
    check("rst_out_pp", out_pp, 160'(0));
    check("rst_exp_max", out_exp_max, 160'(0));
`ifdef ALIGN_STICKY_EN
    check("rst_sticky", out_sticky, 160'(0));
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 160'(in_ready), 160'(1));

    // Basic
    @(posedge clk);
    #1;
    p = '0;
    e = '0;
    p[0 +: PW]  = 5'sd3;
    e[0 +: EW]  = 5'sd2;
    p[PW +: PW] = -5'sd4;
    e[EW +: EW] = 5'sd0;
    send(p, e, 9'b000000011);
    @(negedge clk);
    check("basic_lat1", 160'(out_valid), 160'(0));
    @(negedge clk);
    check("basic_lat2", 160'(out_valid), 160'(1));
    check("basic_lane0", out_pp[15:0], 160'(16'h1800));
    check("basic_lane1", out_pp[31:16], 160'(16'hF800));
    check("basic_rest", out_pp[L*OW-1:32], 160'(0));
    check("basic_max", out_exp_max, 160'(5'd2));
    drain();

    // Overshift
    @(posedge clk);
    #1;
    p = '0;
    e = '0;
    p[0 +: PW]    = 5'sd7;
    e[0 +: EW]    = -5'sd10;
    p[PW +: PW]   = -5'sd1;
    e[EW +: EW]   = -5'sd10;
    p[2*PW +: PW] = 5'sd1;
    e[2*EW +: EW] = 5'sd10;
    send(p, e, 9'b000000111);
    repeat (2) @(negedge clk);
    check("ovs_lane0", out_pp[15:0], 160'(16'h0000));
    check("ovs_lane1", out_pp[31:16], 160'(16'hFFFF));
    check("ovs_lane2", out_pp[47:32], 160'(16'h0800));
`ifdef ALIGN_STICKY_EN
    check("ovs_sticky", out_sticky[2:0], 160'(3'b011));
`endif
    drain();

    // All lanes disabled
    @(posedge clk);
    #1;
    send({$urandom(), 13'h1abc}, {$urandom(), 13'h0f0f}, '0);
    repeat (2) @(negedge clk);
    check("dis_pp", out_pp, 160'(0));
    check("dis_max", out_exp_max, 160'(5'b10000));
    drain();

    // Backpressure: out_ready low on cycles 3..6 of the stream
    base    = popped;
    saw_low = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 5; k++) send_rand();
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1'b1;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("bp_in_ready_low", 160'(saw_low), 160'(1));
    check("bp_count", 160'(popped - base), 160'(5));

    // Back-to-back with full downstream acceptance
    base = popped;
    fork
      begin
        for (int k = 0; k < 20; k++) send_rand();
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          check("b2b_in_ready", 160'(in_ready), 160'(1));
        end
      end
    join
    drain();
    check("b2b_count", 160'(popped - base), 160'(20));

    // Reset with both stages holding beats
    @(posedge clk);
    #1 out_ready = 1'b0;
    send_rand();
    send_rand();
    check("mid_full_valid", 160'(out_valid), 160'(1));
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_out_valid", 160'(out_valid), 160'(0));
    check("mid_out_pp", out_pp, 160'(0));
    check("mid_in_ready", 160'(in_ready), 160'(1));
    base = popped;
    @(posedge clk);
    #1;
    send_rand();
    repeat (2) @(negedge clk);
    drain();
    check("mid_after_count", 160'(popped - base), 160'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
